// File: rtl/fwrisc_wb_arb_pkg.sv
// Shared types and helpers for the fwrisc Wishbone arbitration blocks.
package fwrisc_wb_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Wishbone byte-select width for a given data width
    function automatic int unsigned sel_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/fwrisc_rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first set req bit
// at or above ptr, wrapping modulo N.
module fwrisc_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner_c
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        winner_c = '0;
        found    = 1'b0;
        idx      = ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[idx]) begin
                winner_c[idx] = 1'b1;
                found         = 1'b1;
            end
            idx = (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fwrisc_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N initiators share one target; ownership is
// held for as long as the owner keeps cyc asserted.
module fwrisc_wb_rr_arbiter
    import fwrisc_wb_arb_pkg::*;
#(
    parameter int unsigned N_INITIATORS = 2,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TGC_WIDTH    = 4
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [N_INITIATORS*ADDR_WIDTH-1:0]          i_adr,
    input  logic [N_INITIATORS*DATA_WIDTH-1:0]          i_dat_w,
    input  logic [N_INITIATORS-1:0]                     i_cyc,
    input  logic [N_INITIATORS-1:0]                     i_stb,
    input  logic [N_INITIATORS-1:0]                     i_we,
    input  logic [N_INITIATORS*sel_width(DATA_WIDTH)-1:0] i_sel,
    input  logic [N_INITIATORS*TGC_WIDTH-1:0]           i_tgc,
    output logic [DATA_WIDTH-1:0]                       i_dat_r,
    output logic [N_INITIATORS-1:0]                     i_ack,
    output logic [N_INITIATORS-1:0]                     i_err,
    output logic [ADDR_WIDTH-1:0]                       t_adr,
    output logic [DATA_WIDTH-1:0]                       t_dat_w,
    output logic                                        t_cyc,
    output logic                                        t_stb,
    output logic                                        t_we,
    output logic [sel_width(DATA_WIDTH)-1:0]            t_sel,
    output logic [TGC_WIDTH-1:0]                        t_tgc,
    input  logic [DATA_WIDTH-1:0]                       t_dat_r,
    input  logic                                        t_ack,
    input  logic                                        t_err,
    output logic [N_INITIATORS-1:0]                     gnt
);

    localparam int unsigned N     = N_INITIATORS;
    localparam int unsigned SEL_W = sel_width(DATA_WIDTH);
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE  = ARB_IDLE;
    localparam logic [0:0] OWNED = ARB_OWNED;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [N-1:0]          gnt_nxt;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [N-1:0]          req;
    logic [N-1:0]          pick;

    logic                  owner_cyc;
    logic                  owner_stb;
    logic                  owner_we;
    logic [ADDR_WIDTH-1:0] owner_adr;
    logic [DATA_WIDTH-1:0] owner_dat;
    logic [SEL_W-1:0]      owner_sel;
    logic [TGC_WIDTH-1:0]  owner_tgc;
    logic [PTR_W-1:0]      owner_idx;
    logic                  beat_ack;
    logic                  beat_err;

    assign req = i_cyc & i_stb;

    fwrisc_rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req      (req),
        .ptr      (ptr),
        .winner_c (pick)
    );

    // Select the current owner's request fields (gnt is one-hot or zero)
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        owner_we  = 1'b0;
        owner_adr = '0;
        owner_dat = '0;
        owner_sel = '0;
        owner_tgc = '0;
        owner_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gnt[k]) begin
                owner_cyc = i_cyc[k];
                owner_stb = i_stb[k];
                owner_we  = i_we[k];
                owner_adr = i_adr[k*ADDR_WIDTH +: ADDR_WIDTH];
                owner_dat = i_dat_w[k*DATA_WIDTH +: DATA_WIDTH];
                owner_sel = i_sel[k*SEL_W +: SEL_W];
                owner_tgc = i_tgc[k*TGC_WIDTH +: TGC_WIDTH];
                owner_idx = PTR_W'(k);
            end
        end
    end

    // Target side sees nothing unless the owner is still in its cycle
    assign t_cyc   = owner_cyc;
    assign t_stb   = owner_cyc & owner_stb;
    assign t_we    = owner_cyc & owner_we;
    assign t_adr   = owner_cyc ? owner_adr : '0;
    assign t_dat_w = owner_cyc ? owner_dat : '0;
    assign t_sel   = owner_cyc ? owner_sel : '0;
    assign t_tgc   = owner_cyc ? owner_tgc : '0;

    assign beat_ack = t_ack & t_cyc & t_stb;
    assign beat_err = t_err & t_cyc & t_stb;
    assign i_ack    = gnt & {N{beat_ack}};
    assign i_err    = gnt & {N{beat_err}};
    assign i_dat_r  = t_dat_r;

    // Next-state: grant from IDLE, release (with pointer advance) when owner drops cyc
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = pick;
                    state_nxt = OWNED;
                end
            end
            OWNED: begin
                if (!owner_cyc) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = (owner_idx == PTR_W'(N - 1)) ? '0 : owner_idx + PTR_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_fwrisc_wb_rr_arbiter.sv
// Self-checking bench for fwrisc_wb_rr_arbiter (4 initiators): directed
// scenarios plus random traffic, all checked against a behavioural model.
module tb_fwrisc_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TW = 4;
    localparam logic [TW-1:0] AMOADD = 4'h3;

    logic            clock;
    logic            reset;
    logic [N*AW-1:0] i_adr;
    logic [N*DW-1:0] i_dat_w;
    logic [N-1:0]    i_cyc;
    logic [N-1:0]    i_stb;
    logic [N-1:0]    i_we;
    logic [N*SW-1:0] i_sel;
    logic [N*TW-1:0] i_tgc;
    logic [DW-1:0]   i_dat_r;
    logic [N-1:0]    i_ack;
    logic [N-1:0]    i_err;
    logic [AW-1:0]   t_adr;
    logic [DW-1:0]   t_dat_w;
    logic            t_cyc;
    logic            t_stb;
    logic            t_we;
    logic [SW-1:0]   t_sel;
    logic [TW-1:0]   t_tgc;
    logic [DW-1:0]   t_dat_r;
    logic            t_ack;
    logic            t_err;
    logic [N-1:0]    gnt;

    logic [AW-1:0] adr  [N];
    logic [DW-1:0] wdat [N];
    logic [SW-1:0] sel  [N];
    logic [TW-1:0] tgc  [N];
    logic [N-1:0]  cyc;
    logic [N-1:0]  stb;
    logic [N-1:0]  we;

    int           n_total;
    int           n_pass;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] exp_ack;
    int           ack0_cnt;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            i_adr[k*AW +: AW]   = adr[k];
            i_dat_w[k*DW +: DW] = wdat[k];
            i_sel[k*SW +: SW]   = sel[k];
            i_tgc[k*TW +: TW]   = tgc[k];
        end
    end
    assign i_cyc = cyc;
    assign i_stb = stb;
    assign i_we  = we;

    fwrisc_wb_rr_arbiter #(
        .N_INITIATORS (N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .TGC_WIDTH    (TW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .i_adr   (i_adr),
        .i_dat_w (i_dat_w),
        .i_cyc   (i_cyc),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_sel   (i_sel),
        .i_tgc   (i_tgc),
        .i_dat_r (i_dat_r),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .t_adr   (t_adr),
        .t_dat_w (t_dat_w),
        .t_cyc   (t_cyc),
        .t_stb   (t_stb),
        .t_we    (t_we),
        .t_sel   (t_sel),
        .t_tgc   (t_tgc),
        .t_dat_r (t_dat_r),
        .t_ack   (t_ack),
        .t_err   (t_err),
        .gnt     (gnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < N; k++) begin
            adr[k]  = '0;
            wdat[k] = '0;
            sel[k]  = '0;
            tgc[k]  = '0;
        end
        cyc     = '0;
        stb     = '0;
        we      = '0;
        t_ack   = 1'b0;
        t_err   = 1'b0;
        t_dat_r = '0;
    endtask

    // Expected outputs from the model owner and the current inputs
    task automatic model_compare();
        logic [N-1:0]  eg, eack, eerr;
        logic          ec, es, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] esel;
        logic [TW-1:0] et;
        logic [1:0]    mo;
        eg = '0; eack = '0; eerr = '0;
        ec = 1'b0; es = 1'b0; ewe = 1'b0;
        ea = '0; ed = '0; esel = '0; et = '0;
        if (m_owner >= 0) begin
            mo     = 2'(m_owner);
            eg[mo] = 1'b1;
            if (cyc[mo]) begin
                ec   = 1'b1;
                es   = stb[mo];
                ewe  = we[mo];
                ea   = adr[mo];
                ed   = wdat[mo];
                esel = sel[mo];
                et   = tgc[mo];
                if (es && t_ack) eack[mo] = 1'b1;
                if (es && t_err) eerr[mo] = 1'b1;
            end
        end
        check("gnt", gnt, eg);
        check("t_cyc", t_cyc, ec);
        check("t_stb", t_stb, es);
        check("t_we", t_we, ewe);
        check("t_adr", t_adr, ea);
        check("t_dat_w", t_dat_w, ed);
        check("t_sel", t_sel, esel);
        check("t_tgc", t_tgc, et);
        check("i_ack", i_ack, eack);
        check("i_err", i_err, eerr);
        check("i_dat_r", i_dat_r, t_dat_r);
        exp_ack = eack;
    endtask

    // Advance the model over one clock edge using the pre-edge inputs
    task automatic model_step();
        bit found;
        int k;
        found = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int d = 0; d < N; d++) begin
                k = (m_ptr + d) % N;
                if (!found && cyc[k] && stb[k]) begin
                    m_owner = k;
                    found   = 1'b1;
                end
            end
        end else if (!cyc[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    endtask

    task automatic tick();
        #1;
        model_compare();
        ack0_cnt += int'(i_ack[0]);
        model_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [N-1:0] prev_gnt;
        logic [N-1:0] exp_g;
        int           grants;
        int           ack1_bad;

        n_total  = 0;
        n_pass   = 0;
        ack0_cnt = 0;
        exp_ack  = '0;
        m_owner  = -1;
        m_ptr    = 0;
        clear_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        tick();
        reset = 1'b0;
        tick();

        // Single read from initiator 0 with two wait states
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h1000; sel[0] = 4'hF;
        #1;
        check("t1_no_early_cyc", t_cyc, 1'b0);
        tick();
        #1;
        check("t1_adr", t_adr, 32'h1000);
        check("t1_gnt", gnt, 4'b0001);
        ack0_cnt = 0;
        tick();
        tick();
        t_ack = 1'b1; t_dat_r = 32'hDEADBEEF;
        #1;
        check("t1_ack", i_ack, 4'b0001);
        check("t1_dat_r", i_dat_r, 32'hDEADBEEF);
        tick();
        cyc[0] = 1'b0; stb[0] = 1'b0; t_ack = 1'b0; t_dat_r = '0;
        #1;
        check("t1_gnt_hold", gnt, 4'b0001);
        check("t1_tcyc_drop", t_cyc, 1'b0);
        tick();
        #1;
        check("t1_gnt_released", gnt, 4'b0000);
        check("t1_ack_pulses", 64'(ack0_cnt), 64'd1);
        tick();

        // Contention: initiators 0 and 1 issue back-to-back single writes
        prev_gnt = '0;
        exp_g    = 4'b0010;
        grants   = 0;
        ack1_bad = 0;
        t_ack    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (exp_ack[k]) begin
                    cyc[k] = 1'b0;
                end else if (!cyc[k]) begin
                    cyc[k]  = 1'b1;
                    adr[k]  = $urandom;
                    wdat[k] = $urandom;
                    sel[k]  = 4'(k + 1);
                end
                stb[k] = cyc[k];
                we[k]  = 1'b1;
            end
            #1;
            if (gnt != '0 && prev_gnt == '0) begin
                check("t2_order", gnt, exp_g);
                exp_g  = (exp_g == 4'b0001) ? 4'b0010 : 4'b0001;
                grants++;
            end else if (gnt != '0) begin
                check("t2_no_direct_switch", gnt, prev_gnt);
            end
            if (gnt == 4'b0001 && i_ack[1]) ack1_bad++;
            prev_gnt = gnt;
            tick();
        end
        check("t2_grant_count", 64'(grants >= 8), 64'd1);
        check("t2_no_ack1_while_g0", 64'(ack1_bad), 64'd0);
        clear_inputs();
        tick();
        tick();
        tick();

        // AMO lock: initiator 1 holds cyc over a read and a write beat
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; tgc[1] = AMOADD; adr[1] = 32'h2000;
        tick();
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h3000; tgc[0] = 4'h0;
        t_ack = 1'b1; t_dat_r = 32'h55;
        #1;
        check("t3_gnt_beat1", gnt, 4'b0010);
        check("t3_tgc_beat1", t_tgc, AMOADD);
        check("t3_ack_beat1", i_ack, 4'b0010);
        tick();
        stb[1] = 1'b0;
        #1;
        check("t3_ack_stb_low", i_ack, 4'b0000);
        check("t3_gnt_gap", gnt, 4'b0010);
        tick();
        stb[1] = 1'b1; we[1] = 1'b1; wdat[1] = 32'h56;
        #1;
        check("t3_gnt_beat2", gnt, 4'b0010);
        check("t3_tgc_beat2", t_tgc, AMOADD);
        check("t3_we_beat2", t_we, 1'b1);
        check("t3_ack_beat2", i_ack, 4'b0010);
        tick();
        cyc[1] = 1'b0; stb[1] = 1'b0; t_ack = 1'b0;
        #1;
        check("t3_gnt_last", gnt, 4'b0010);
        tick();
        #1;
        check("t3_turnaround", gnt, 4'b0000);
        tick();
        t_ack = 1'b1;
        #1;
        check("t3_gnt0", gnt, 4'b0001);
        tick();
        clear_inputs();
        tick();
        tick();

        // Error path on an initiator 0 write
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; wdat[0] = 32'hA5A5A5A5;
        tick();
        cyc[1] = 1'b1; stb[1] = 1'b1; t_err = 1'b1;
        #1;
        check("t4_err0", i_err, 4'b0001);
        check("t4_no_ack", i_ack, 4'b0000);
        tick();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        check("t4_err_one_cycle", i_err, 4'b0000);
        tick();
        t_err = 1'b0;
        tick();
        tick();
        clear_inputs();
        tick();
        tick();

        // Wrap-around: pointer at 3 with requests from 3 and 1
        cyc[2] = 1'b1; stb[2] = 1'b1;
        tick();
        cyc[2] = 1'b0; stb[2] = 1'b0;
        tick();
        cyc[3] = 1'b1; stb[3] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        #1;
        check("t5_idle", gnt, 4'b0000);
        tick();
        cyc[3] = 1'b0; stb[3] = 1'b0;
        #1;
        check("t5_wrap_first", gnt, 4'b1000);
        tick();
        tick();
        #1;
        check("t5_wrap_next", gnt, 4'b0010);
        clear_inputs();
        tick();
        tick();

        // Reset mid-transfer while initiator 1 owns the bus
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
        cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        tick();
        #1;
        check("t6_pre_owner", gnt, 4'b0010);
        check("t6_pre_stb", t_stb, 1'b1);
        reset   = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        #1;
        check("t6_async_tcyc", t_cyc, 1'b0);
        check("t6_async_gnt", gnt, 4'b0000);
        tick();
        reset = 1'b0;
        tick();
        #1;
        check("t6_ptr_from_0", gnt, 4'b0001);
        clear_inputs();
        tick();
        tick();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(3) == 0) cyc[k] = ~cyc[k];
                stb[k]  = 1'($urandom_range(1));
                we[k]   = 1'($urandom_range(1));
                adr[k]  = $urandom;
                wdat[k] = $urandom;
                sel[k]  = 4'($urandom);
                tgc[k]  = 4'($urandom);
            end
            t_ack   = 1'($urandom_range(1));
            t_err   = ($urandom_range(3) == 0);
            t_dat_r = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
